cpu_core: RTL and testbench
===========================

# cpu_core

Multi-cycle 8-bit 6502-subset processor core, the parametrised successor to the original fetch/decode/exec core. Adds reset-vector fetch, zero-page and absolute addressing, stores, X/Y loads, N/Z/C flags, a wait-state input and an illegal-opcode halt. Sits between the `alu` instance it owns and the system memory bus. Memory has one-cycle read latency.

## Interface
- `ADDR_W`, 16: address bus and PC width, 8..16; wider internal addresses are truncated to the low `ADDR_W` bits.
- `RESET_VEC`, 16'hFFFC: address of the reset vector low byte; the high byte is at `RESET_VEC+1`.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rdy`  in  1  high = proceed; low stalls read cycles.
- `RW`  out  1  1 = read, 0 = write.
- `AD`  out  ADDR_W  bus address.
- `D_in`  in  8  read data, valid the cycle after its address.
- `D_out`  out  8  write data, valid when `RW`=0.
- `sync`  out  1  high in FETCH cycles.
- `halt`  out  1  high in HALT.

## Operation
- States: RST0, RST1, RST2, FETCH, DECODE, OPLO, ADDR, EXEC, WRITE, JUMP, BRANCH, HALT.
- Reset (async): state RST0, `PC`=0, `A`=`X`=`Y`=0, `P`=0, `RW`=1, `sync`=0, `halt`=0, `D_out`=0.
- Reset sequence:
  - RST0: `AD`=`RESET_VEC`.
  - RST1: `AD`=`RESET_VEC+1`, latch `D_in` as the low byte.
  - RST2: `PC`={`D_in`, low byte}.
  - Then FETCH.
- FETCH: `AD`=`PC`, `PC`+1.
- DECODE: opcode is on `D_in`.
  - Implied (NOP EA, INX E8, CLC 18, SEC 38): execute and return to FETCH.
  - Any other legal opcode: `AD`=`PC`, `PC`+1.
- Immediate (LDA A9, LDX A2, LDY A0, ADC 69, AND 29, ORA 09): DECODE then EXEC. EXEC applies the operand.
- Zero page (LDA A5, ADC 65, AND 25, ORA 05): DECODE, then ADDR with `AD`={0, `D_in`}, then EXEC.
- Absolute (LDA AD, ADC 6D): DECODE, then OPLO (latch low byte, `AD`=`PC`, `PC`+1), then ADDR with `AD`={`D_in`, low}, then EXEC.
- STA zp 85: DECODE, then WRITE with `AD`={0, `D_in`}, `RW`=0, `D_out`=`A`.
- STA abs 8D: DECODE, OPLO, then WRITE with `AD`={`D_in`, low}.
- JMP abs 4C: DECODE, OPLO, then JUMP: `PC`={`D_in`, low}.
- Flags:
  - N=result[7], Z=(result==0), on every A/X/Y write.
  - C = carry out of ADC; ADC uses C as carry-in.
  - CLC/SEC write C only.
  - INX wraps FF to 00.
- Any other opcode: go to HALT, assert `halt`, no bus writes. Only `rst_n` exits HALT.
- `rdy` low in any state except WRITE: state, registers and `AD` hold. WRITE completes regardless of `rdy`.

## Timing
- Cycles per instruction:
  - Implied: 2.
  - Immediate, STA zp, branch: 3.
  - Zero-page read, STA abs, JMP: 4.
  - Absolute read: 5.
  - Reset sequence: 3 cycles, then first FETCH.
- Register results are visible from the edge that ends EXEC/DECODE.
- `D_out` is registered; it equals `A` in WRITE.
- `AD` and `RW` are combinational from state and registers.
- Reset asserted mid-write: `RW` returns to 1 immediately.

## Configuration
- `CPU_BRANCH_EN` defined: BEQ F0, BNE D0, BCS B0, BCC 90 are compiled in.
  - Sequence: DECODE, then BRANCH. BRANCH: if taken, `PC` = `PC` + sign-extended `D_in`, wrapping modulo 2^`ADDR_W`; then FETCH.
  - The not-taken path is also 3 cycles.
- Undefined: these four opcodes are illegal and go to HALT.

## Structure
- Package `cpu_pkg`:
  - State enum.
  - Opcode constants.
  - Flag bit indices: C=0, Z=1, N=7.
- Single sub-module `cpu_decode`: combinational opcode to {class, ALU op, destination register, legal} lookup.
- Existing `alu` is reused unchanged.

## Test plan
- Vector bytes 00/80 at `RESET_VEC`, release `rst_n` -> first `sync` with `AD`=8000 on cycle 4.
- A9 7F, 69 01 with C=0 -> `A`=80, N=1, Z=0, C=0; the pair takes 6 cycles.
- A9 42, 8D 34 12 -> write cycle with `AD`=1234, `RW`=0, `D_out`=42.
- A5 10 with mem[0010]=00 -> `A`=00, Z=1. Hold `rdy` low 3 cycles during ADDR -> `AD` stays 0010 and the total is 7 cycles.
- Opcode 02 -> `halt`=1, `AD` frozen, no `RW`=0 for 20 cycles. Pulse `rst_n` -> vector refetch.
- With `CPU_BRANCH_EN`, Z=1, F0 FC at 8000 -> next FETCH at 7FFE. Without the macro -> `halt`=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu_core 6502-subset processor:
// FSM state encoding, decode result fields, opcode values and flag positions.
package cpu_pkg;

    typedef enum logic [3:0] {
        RST0, RST1, RST2, FETCH, DECODE, OPLO, ADDR, EXEC, WRITE, JUMP, BRANCH, HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_IMPL, CL_IMM, CL_ZP, CL_ABS, CL_STZ, CL_STA, CL_JMP, CL_BR
    } op_class_t;

    typedef enum logic [2:0] {
        ALU_NOP, ALU_PASS, ALU_ADC, ALU_AND, ALU_ORA, ALU_INC, ALU_CLC, ALU_SEC
    } alu_op_t;

    typedef enum logic [1:0] {
        DST_NONE, DST_A, DST_X, DST_Y
    } dest_t;

    typedef struct packed {
        op_class_t cls;
        alu_op_t   alu_op;
        dest_t     dest;
        logic      legal;
    } dec_t;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 7;

    localparam logic [7:0] OP_NOP     = 8'hEA;
    localparam logic [7:0] OP_INX     = 8'hE8;
    localparam logic [7:0] OP_CLC     = 8'h18;
    localparam logic [7:0] OP_SEC     = 8'h38;
    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_LDX_IMM = 8'hA2;
    localparam logic [7:0] OP_LDY_IMM = 8'hA0;
    localparam logic [7:0] OP_ADC_IMM = 8'h69;
    localparam logic [7:0] OP_AND_IMM = 8'h29;
    localparam logic [7:0] OP_ORA_IMM = 8'h09;
    localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
    localparam logic [7:0] OP_ADC_ZP  = 8'h65;
    localparam logic [7:0] OP_AND_ZP  = 8'h25;
    localparam logic [7:0] OP_ORA_ZP  = 8'h05;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_ADC_ABS = 8'h6D;
    localparam logic [7:0] OP_STA_ZP  = 8'h85;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;
    localparam logic [7:0] OP_BEQ     = 8'hF0;
    localparam logic [7:0] OP_BNE     = 8'hD0;
    localparam logic [7:0] OP_BCS     = 8'hB0;
    localparam logic [7:0] OP_BCC     = 8'h90;

endpackage

// File: rtl/alu.sv
// 8-bit ALU used by cpu_core: pass-through, add-with-carry, AND, OR,
// increment, and explicit carry clear/set.
module alu
    import cpu_pkg::*;
(
    input  alu_op_t    op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] y,
    output logic       cout
);

    // Result and carry for the selected operation; carry passes through by default.
    always_comb begin
        y    = b;
        cout = cin;
        case (op)
            ALU_PASS: y = b;
            ALU_ADC:  {cout, y} = {1'b0, a} + {1'b0, b} + {8'h00, cin};
            ALU_AND:  y = a & b;
            ALU_ORA:  y = a | b;
            ALU_INC:  y = a + 8'd1;
            ALU_CLC:  cout = 1'b0;
            ALU_SEC:  cout = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: rtl/cpu_decode.sv
// Opcode lookup: class, ALU operation, destination register and legality.
// Branches (BEQ/BNE/BCS/BCC) are legal only when CPU_BRANCH_EN is defined;
// otherwise they decode as illegal and halt the core.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [7:0] opcode,
    output dec_t       dec
);

    // Pure table lookup; anything not listed is illegal.
    always_comb begin
        dec = '{CL_IMPL, ALU_NOP, DST_NONE, 1'b0};
        case (opcode)
            OP_NOP:     dec = '{CL_IMPL, ALU_NOP,  DST_NONE, 1'b1};
            OP_INX:     dec = '{CL_IMPL, ALU_INC,  DST_X,    1'b1};
            OP_CLC:     dec = '{CL_IMPL, ALU_CLC,  DST_NONE, 1'b1};
            OP_SEC:     dec = '{CL_IMPL, ALU_SEC,  DST_NONE, 1'b1};
            OP_LDA_IMM: dec = '{CL_IMM,  ALU_PASS, DST_A,    1'b1};
            OP_LDX_IMM: dec = '{CL_IMM,  ALU_PASS, DST_X,    1'b1};
            OP_LDY_IMM: dec = '{CL_IMM,  ALU_PASS, DST_Y,    1'b1};
            OP_ADC_IMM: dec = '{CL_IMM,  ALU_ADC,  DST_A,    1'b1};
            OP_AND_IMM: dec = '{CL_IMM,  ALU_AND,  DST_A,    1'b1};
            OP_ORA_IMM: dec = '{CL_IMM,  ALU_ORA,  DST_A,    1'b1};
            OP_LDA_ZP:  dec = '{CL_ZP,   ALU_PASS, DST_A,    1'b1};
            OP_ADC_ZP:  dec = '{CL_ZP,   ALU_ADC,  DST_A,    1'b1};
            OP_AND_ZP:  dec = '{CL_ZP,   ALU_AND,  DST_A,    1'b1};
            OP_ORA_ZP:  dec = '{CL_ZP,   ALU_ORA,  DST_A,    1'b1};
            OP_LDA_ABS: dec = '{CL_ABS,  ALU_PASS, DST_A,    1'b1};
            OP_ADC_ABS: dec = '{CL_ABS,  ALU_ADC,  DST_A,    1'b1};
            OP_STA_ZP:  dec = '{CL_STZ,  ALU_NOP,  DST_NONE, 1'b1};
            OP_STA_ABS: dec = '{CL_STA,  ALU_NOP,  DST_NONE, 1'b1};
            OP_JMP_ABS: dec = '{CL_JMP,  ALU_NOP,  DST_NONE, 1'b1};
`ifdef CPU_BRANCH_EN
            OP_BEQ, OP_BNE, OP_BCS, OP_BCC:
                        dec = '{CL_BR,   ALU_NOP,  DST_NONE, 1'b1};
`else
`endif
            default:    ;
        endcase
    end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle 8-bit 6502-subset core with reset-vector fetch, zp/abs
// addressing, stores, N/Z/C flags, rdy wait states and illegal-opcode halt.
// Memory returns read data one cycle after the address. Conditional
// branches are compiled in when CPU_BRANCH_EN is defined (see cpu_decode).
//
// state  | meaning
// RST0   | drive low vector address
// RST1   | drive high vector address, latch low byte
// RST2   | load PC from vector
// FETCH  | drive PC, PC+1
// DECODE | opcode on D_in; implied ops execute here
// OPLO   | latch absolute low byte, fetch high byte
// ADDR   | drive effective address for a read
// EXEC   | operand on D_in, update registers/flags
// WRITE  | store A at effective address
// JUMP   | load PC from absolute operand
// BRANCH | apply relative offset if condition holds
// HALT   | illegal opcode, wait for reset
module cpu_core
    import cpu_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter logic [15:0] RESET_VEC = 16'hFFFC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    output logic              RW,
    output logic [ADDR_W-1:0] AD,
    input  logic [7:0]        D_in,
    output logic [7:0]        D_out,
    output logic              sync,
    output logic              halt
);

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [7:0]        a_q, x_q, y_q, p_q;
    logic [7:0]        lo_q, ir_q, din_q;
    logic              stall_q;
    logic              stall, commit, br_taken, alu_c;
    logic [7:0]        din, opcode, alu_a, alu_y;
    logic [15:0]       ad16, tgt16, off16;
    dec_t              dec;

    // During a stall the bus keeps returning data for the held address, so the
    // byte that belongs to the current state is replayed from din_q.
    assign stall    = !rdy && (state_q != WRITE);
    assign din      = stall_q ? din_q : D_in;
    assign opcode   = (state_q == DECODE) ? din : ir_q;
    assign alu_a    = (state_q == DECODE) ? x_q : a_q;
    assign tgt16    = {din, lo_q};
    assign off16    = {{8{din[7]}}, din};
    assign commit   = !stall && ((state_q == EXEC) ||
                      (state_q == DECODE && dec.legal && dec.cls == CL_IMPL));
    assign sync     = (state_q == FETCH);
    assign halt     = (state_q == HALT);
    assign AD       = ad16[ADDR_W-1:0];

    cpu_decode u_decode (
        .opcode (opcode),
        .dec    (dec)
    );

    alu u_alu (
        .op   (dec.alu_op),
        .a    (alu_a),
        .b    (din),
        .cin  (p_q[FLAG_C]),
        .y    (alu_y),
        .cout (alu_c)
    );

    // Branch condition from the latched opcode and current flags.
    always_comb begin
        case (ir_q)
            OP_BEQ:  br_taken = p_q[FLAG_Z];
            OP_BNE:  br_taken = !p_q[FLAG_Z];
            OP_BCS:  br_taken = p_q[FLAG_C];
            OP_BCC:  br_taken = !p_q[FLAG_C];
            default: br_taken = 1'b0;
        endcase
    end

    // Bus address and direction decoded from state and latched bytes.
    always_comb begin
        ad16 = 16'(pc_q);
        RW   = 1'b1;
        case (state_q)
            RST0:  ad16 = RESET_VEC;
            RST1:  ad16 = RESET_VEC + 16'd1;
            ADDR:  ad16 = (dec.cls == CL_ZP) ? {8'h00, din} : tgt16;
            WRITE: begin
                ad16 = (dec.cls == CL_STZ) ? {8'h00, din} : tgt16;
                RW   = 1'b0;
            end
            default: ;
        endcase
    end

    // Architectural registers and flags, written at the end of EXEC or an implied DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= 8'h00;
            x_q <= 8'h00;
            y_q <= 8'h00;
            p_q <= 8'h00;
        end else if (commit) begin
            case (dec.dest)
                DST_A:   a_q <= alu_y;
                DST_X:   x_q <= alu_y;
                DST_Y:   y_q <= alu_y;
                default: ;
            endcase
            if (dec.dest != DST_NONE) begin
                p_q[FLAG_N] <= alu_y[7];
                p_q[FLAG_Z] <= (alu_y == 8'h00);
            end
            if (dec.alu_op inside {ALU_ADC, ALU_CLC, ALU_SEC})
                p_q[FLAG_C] <= alu_c;
        end
    end

    // Sequencer: state, PC, byte latches and write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST0;
            pc_q    <= '0;
            lo_q    <= 8'h00;
            ir_q    <= 8'h00;
            din_q   <= 8'h00;
            stall_q <= 1'b0;
            D_out   <= 8'h00;
        end else begin
            stall_q <= stall;
            din_q   <= din;
            if (!stall) begin
                case (state_q)
                    RST0: state_q <= RST1;
                    RST1: begin
                        lo_q    <= din;
                        state_q <= RST2;
                    end
                    RST2: begin
                        pc_q    <= tgt16[ADDR_W-1:0];
                        state_q <= FETCH;
                    end
                    FETCH: begin
                        pc_q    <= pc_q + PC_ONE;
                        state_q <= DECODE;
                    end
                    DECODE: begin
                        ir_q <= din;
                        if (!dec.legal) begin
                            state_q <= HALT;
                        end else if (dec.cls == CL_IMPL) begin
                            state_q <= FETCH;
                        end else begin
                            pc_q <= pc_q + PC_ONE;
                            case (dec.cls)
                                CL_IMM:  state_q <= EXEC;
                                CL_ZP:   state_q <= ADDR;
                                CL_BR:   state_q <= BRANCH;
                                CL_STZ: begin
                                    D_out   <= a_q;
                                    state_q <= WRITE;
                                end
                                default: state_q <= OPLO;
                            endcase
                        end
                    end
                    OPLO: begin
                        lo_q <= din;
                        pc_q <= pc_q + PC_ONE;
                        case (dec.cls)
                            CL_STA: begin
                                D_out   <= a_q;
                                state_q <= WRITE;
                            end
                            CL_JMP:  state_q <= JUMP;
                            default: state_q <= ADDR;
                        endcase
                    end
                    ADDR:  state_q <= EXEC;
                    EXEC:  state_q <= FETCH;
                    WRITE: state_q <= FETCH;
                    JUMP: begin
                        pc_q    <= tgt16[ADDR_W-1:0];
                        state_q <= FETCH;
                    end
                    BRANCH: begin
                        if (br_taken)
                            pc_q <= pc_q + off16[ADDR_W-1:0];
                        state_q <= FETCH;
                    end
                    HALT:    state_q <= HALT;
                    default: state_q <= HALT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: directed reset/flag/store/wait-state/halt/
// branch steps plus a randomized instruction stream checked against an
// instruction-level model of the architectural state.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        RW;
    logic [15:0] AD;
    logic [7:0]  D_in;
    logic [7:0]  D_out;
    logic        sync;
    logic        halt;

    logic [7:0]  mem [0:65535];
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    int          wr_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    cpu_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .RW    (RW),
        .AD    (AD),
        .D_in  (D_in),
        .D_out (D_out),
        .sync  (sync),
        .halt  (halt)
    );

    always #5 clk = ~clk;

    // one-cycle read latency memory
    always @(posedge clk) D_in <= mem[AD];

    // record every bus write in the middle of its cycle
    always @(negedge clk) begin
        if (rst_n && RW === 1'b0) begin
            wr_cnt  = wr_cnt + 1;
            wr_addr = AD;
            wr_data = D_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // cycles until the next FETCH cycle, bounded
    task automatic next_fetch(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (sync !== 1'b1 && n < 40);
    endtask

    task automatic set_vec(input logic [15:0] v);
        mem[16'hFFFC] = v[7:0];
        mem[16'hFFFD] = v[15:8];
    endtask

    initial begin
        int          n, n2, k, len, cyc, mode, sum, wr0;
        int          acc, xr, yr, c, nf, zf;
        logic [7:0]  opc, v, zp;
        logic [15:0] pc, ea, had, exp_wa;
        logic [7:0]  ops [0:17];
        bit          store;

        ops = '{8'hEA, 8'hE8, 8'h18, 8'h38, 8'hA9, 8'hA2, 8'hA0, 8'h69, 8'h29,
                8'h09, 8'hA5, 8'h65, 8'h25, 8'h05, 8'hAD, 8'h6D, 8'h85, 8'h8D};
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        // directed program: ADC overflow into N, STA abs, LDA zp with wait states
        set_vec(16'h8000);
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h7F;
        mem[16'h8002] = 8'h69; mem[16'h8003] = 8'h01;
        mem[16'h8004] = 8'hA9; mem[16'h8005] = 8'h42;
        mem[16'h8006] = 8'h8D; mem[16'h8007] = 8'h34; mem[16'h8008] = 8'h12;
        mem[16'h8009] = 8'hA5; mem[16'h800A] = 8'h10;
        mem[16'h0010] = 8'h00;

        tick(); tick();
        chk("rst_rw",    32'(RW),    1);
        chk("rst_sync",  32'(sync),  0);
        chk("rst_halt",  32'(halt),  0);
        chk("rst_dout",  32'(D_out), 0);
        chk("rst_ad",    32'(AD),    32'hFFFC);

        rst_n = 1'b1;
        next_fetch(n);
        chk("reset_latency", n, 3);
        chk("first_fetch_ad", 32'(AD), 32'h8000);

        next_fetch(n);
        next_fetch(n2);
        chk("lda_adc_cycles", n + n2, 6);
        chk("lda_adc_ad", 32'(AD), 32'h8004);
        chk("adc_a", 32'(dut.a_q), 32'h80);
        chk("adc_p", 32'(dut.p_q), 32'h80);

        wr0 = wr_cnt;
        next_fetch(n);
        next_fetch(n2);
        chk("sta_abs_cycles", n2, 4);
        chk("sta_abs_count", wr_cnt, wr0 + 1);
        chk("sta_abs_addr", 32'(wr_addr), 32'h1234);
        chk("sta_abs_data", 32'(wr_data), 32'h42);

        // LDA zp with rdy low for 3 cycles of ADDR
        tick(); tick();
        rdy = 1'b0;
        chk("stall_ad0", 32'(AD), 32'h0010);
        tick(); chk("stall_ad1", 32'(AD), 32'h0010);
        tick(); chk("stall_ad2", 32'(AD), 32'h0010);
        tick(); rdy = 1'b1;
        chk("stall_ad3", 32'(AD), 32'h0010);
        next_fetch(n);
        chk("stall_total_cycles", 5 + n, 7);
        chk("ldazp_a", 32'(dut.a_q), 0);
        chk("ldazp_p", 32'(dut.p_q), 32'h02);

        // randomized instruction stream against an instruction-level model
        acc = 0; xr = 0; yr = 0; c = 0; nf = 0; zf = 1;
        pc = 16'h800B;
        for (int i = 0; i < 40; i++) begin
            k    = int'($urandom_range(0, 17));
            opc  = ops[k];
            v    = 8'($urandom);
            zp   = 8'($urandom);
            ea   = 16'h2000 + 16'($urandom_range(0, 8191));
            store = 1'b0;
            exp_wa = 16'h0000;
            case (opc)
                8'hEA, 8'hE8, 8'h18, 8'h38:               mode = 0;
                8'hA9, 8'hA2, 8'hA0, 8'h69, 8'h29, 8'h09: mode = 1;
                8'hA5, 8'h65, 8'h25, 8'h05:               mode = 2;
                8'hAD, 8'h6D:                             mode = 3;
                8'h85:                                    mode = 4;
                default:                                  mode = 5;
            endcase
            mem[pc] = opc;
            case (mode)
                0: begin len = 1; cyc = 2; end
                1: begin len = 2; cyc = 3; mem[pc + 16'd1] = v; end
                2: begin len = 2; cyc = 4; mem[pc + 16'd1] = zp; mem[{8'h00, zp}] = v; end
                3: begin len = 3; cyc = 5; mem[pc + 16'd1] = ea[7:0];
                         mem[pc + 16'd2] = ea[15:8]; mem[ea] = v; end
                4: begin len = 2; cyc = 3; mem[pc + 16'd1] = zp;
                         store = 1'b1; exp_wa = {8'h00, zp}; end
                default: begin len = 3; cyc = 4; mem[pc + 16'd1] = ea[7:0];
                         mem[pc + 16'd2] = ea[15:8]; store = 1'b1; exp_wa = ea; end
            endcase
            case (opc)
                8'hA9, 8'hA5, 8'hAD: begin acc = v; nf = acc / 128; zf = (acc == 0); end
                8'hA2: begin xr = v; nf = xr / 128; zf = (xr == 0); end
                8'hA0: begin yr = v; nf = yr / 128; zf = (yr == 0); end
                8'h69, 8'h65, 8'h6D: begin
                    sum = acc + int'(v) + c;
                    c = (sum > 255) ? 1 : 0;
                    acc = sum % 256; nf = acc / 128; zf = (acc == 0);
                end
                8'h29, 8'h25: begin acc = acc & int'(v); nf = acc / 128; zf = (acc == 0); end
                8'h09, 8'h05: begin acc = acc | int'(v); nf = acc / 128; zf = (acc == 0); end
                8'hE8: begin xr = (xr + 1) % 256; nf = xr / 128; zf = (xr == 0); end
                8'h18: c = 0;
                8'h38: c = 1;
                default: ;
            endcase
            wr0 = wr_cnt;
            next_fetch(n);
            pc = pc + 16'(len);
            chk("rnd_cycles", n, cyc);
            chk("rnd_pc", 32'(AD), 32'(pc));
            chk("rnd_a", 32'(dut.a_q), acc);
            chk("rnd_x", 32'(dut.x_q), xr);
            chk("rnd_y", 32'(dut.y_q), yr);
            chk("rnd_p", 32'(dut.p_q), nf * 128 + zf * 2 + c);
            if (store) begin
                chk("rnd_st_count", wr_cnt, wr0 + 1);
                chk("rnd_st_addr", 32'(wr_addr), 32'(exp_wa));
                chk("rnd_st_data", 32'(wr_data), acc);
            end
        end

        // illegal opcode halts with frozen bus and no writes
        mem[pc] = 8'h02;
        tick(); tick();
        chk("halt_set", 32'(halt), 1);
        had = AD;
        wr0 = wr_cnt;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("halt_ad", 32'(AD), 32'(had));
            chk("halt_rw", 32'(RW), 1);
        end
        chk("halt_hold", 32'(halt), 1);
        chk("halt_no_write", wr_cnt, wr0);
        rst_n = 1'b0;
        #1;
        chk("halt_rst_ad", 32'(AD), 32'hFFFC);
        chk("halt_rst_clear", 32'(halt), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("refetch_hi_ad", 32'(AD), 32'hFFFD);
        next_fetch(n);
        chk("refetch_cycles", n, 2);
        chk("refetch_ad", 32'(AD), 32'h8000);

`ifdef CPU_BRANCH_EN
        // Z=1 then BEQ back across a page boundary, then BNE not taken
        set_vec(16'h7FF0);
        mem[16'h7FF0] = 8'hA9; mem[16'h7FF1] = 8'h00;
        mem[16'h7FF2] = 8'h4C; mem[16'h7FF3] = 8'h00; mem[16'h7FF4] = 8'h80;
        mem[16'h8000] = 8'hF0; mem[16'h8001] = 8'hFC;
        mem[16'h7FFE] = 8'hD0; mem[16'h7FFF] = 8'h10;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        next_fetch(n);
        chk("br_vec_ad", 32'(AD), 32'h7FF0);
        next_fetch(n);
        next_fetch(n);
        chk("jmp_cycles", n, 4);
        chk("jmp_ad", 32'(AD), 32'h8000);
        next_fetch(n);
        chk("beq_cycles", n, 3);
        chk("beq_target", 32'(AD), 32'h7FFE);
        next_fetch(n);
        chk("bne_nt_cycles", n, 3);
        chk("bne_nt_ad", 32'(AD), 32'h8000);
`else
        set_vec(16'h8000);
        mem[16'h8000] = 8'hF0; mem[16'h8001] = 8'hFC;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        next_fetch(n);
        tick(); tick();
        chk("beq_illegal_halt", 32'(halt), 1);
`endif

        // reset during a write cycle drops RW at once
        set_vec(16'h8000);
        mem[16'h8000] = 8'h85; mem[16'h8001] = 8'h20;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        next_fetch(n);
        tick(); tick();
        chk("midwr_rw0", 32'(RW), 0);
        chk("midwr_ad", 32'(AD), 32'h0020);
        rst_n = 1'b0;
        #1;
        chk("midwr_rw1", 32'(RW), 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
